// File: rtl/surf4_spi_wb_bridge.sv
// surf4_spi_wb_bridge: SPI mode-0 slave that turns 64-bit frames (cmd, addr, dummy, data) into single
// WISHBONE classic cycles. The cmd byte returns status {err_o, busy, 6'b0}. A cycle without ack is aborted after TIMEOUT clocks.
// Optional burst continuation (address + 4 per extra data word) is enabled by defining SURF4_SPI_WB_BURST_EN.
module surf4_spi_wb_bridge #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        SCK,
  input  logic        CS_B,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  output logic        err_o
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic WB_IDLE = 1'b0;
  localparam logic WB_BUSY = 1'b1;

  logic [1:0]    sck_sync, cs_sync, mosi_sync;
  logic          sck_s, cs_s, mosi_s;
  logic          sck_d, cs_d;
  logic          sck_rise, sck_fall, cs_fall;

  logic [2:0]    spi_state;
  logic [4:0]    bit_cnt;
  logic [31:0]   rx_sr, rx_next;
  logic [7:0]    st_sr;
  logic          cmd_we;
  logic [15:0]   adr_q;
  logic          miso_q;

  logic          req_vld, req_we;
  logic [15:0]   req_adr;
  logic [31:0]   req_dat;

  logic          wb_state;
  logic [TW-1:0] wb_timer;
  logic [31:0]   rd_dat;
  logic          busy;
  logic          err_clr;

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // cs_d starts low, so a fall can only be seen after CS_B has been observed high.
  assign cs_fall  = ~cs_s & cs_d;
  assign rx_next  = {rx_sr[30:0], mosi_s};
  assign busy     = (wb_state == WB_BUSY);
  // The master has sampled the whole status byte on the 8th rise of the frame.
  assign err_clr  = (spi_state == S_CMD) && !cs_s && sck_rise && (bit_cnt == 5'd7);

  assign wb_sel_o = 4'hF;
  assign MISO     = miso_q;
  // Gated with the raw pin so the driver releases as soon as the master deselects.
  assign MISO_OE  = (spi_state != S_IDLE) && !CS_B;

  // Bring the SPI pins into the clk_i domain and keep one cycle of history for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], SCK};
      cs_sync   <= {cs_sync[0], CS_B};
      mosi_sync <= {mosi_sync[0], MOSI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  // SPI frame sequencer: shifts MOSI in on SCK rise, drives MISO on SCK fall, and issues WB requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spi_state <= S_IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      st_sr     <= '0;
      cmd_we    <= 1'b0;
      adr_q     <= '0;
      miso_q    <= 1'b0;
      req_vld   <= 1'b0;
      req_we    <= 1'b0;
      req_adr   <= '0;
      req_dat   <= '0;
    end else begin
      req_vld <= 1'b0;
      if (sck_rise) rx_sr <= rx_next;
      if (cs_s && (spi_state != S_IDLE)) begin
        spi_state <= S_IDLE;
        miso_q    <= 1'b0;
      end else begin
        case (spi_state)
          S_IDLE: begin
            if (cs_fall) begin
              spi_state <= S_CMD;
              bit_cnt   <= '0;
              miso_q    <= err_o;
              st_sr     <= {busy, 7'b0};
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                cmd_we    <= rx_next[7];
                spi_state <= S_ADDR;
                bit_cnt   <= '0;
              end
            end
            if (sck_fall) begin
              miso_q <= st_sr[7];
              st_sr  <= {st_sr[6:0], 1'b0};
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                adr_q     <= rx_next[15:0];
                spi_state <= S_DUMMY;
                bit_cnt   <= '0;
                // Reads launch here so data is back before the dummy byte ends.
                if (!cmd_we) begin
                  req_vld <= 1'b1;
                  req_we  <= 1'b0;
                  req_adr <= rx_next[15:0];
                end
              end
            end
            if (sck_fall) miso_q <= 1'b0;
          end
          S_DUMMY: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                spi_state <= S_DATA;
                bit_cnt   <= '0;
              end
            end
            if (sck_fall) miso_q <= 1'b0;
          end
          S_DATA: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                spi_state <= S_DONE;
                bit_cnt   <= '0;
                if (cmd_we) begin
                  req_vld <= 1'b1;
                  req_we  <= 1'b1;
                  req_adr <= adr_q;
                  req_dat <= rx_next;
                end
              end
            end
            // Indexing the live read register means a late ack shows up from the next bit on.
            if (sck_fall) miso_q <= cmd_we ? 1'b0 : rd_dat[~bit_cnt];
          end
          S_DONE: begin
`ifdef SURF4_SPI_WB_BURST_EN
            spi_state <= S_DATA;
            bit_cnt   <= '0;
            adr_q     <= adr_q + 16'd4;
            if (!cmd_we) begin
              req_vld <= 1'b1;
              req_we  <= 1'b0;
              req_adr <= adr_q + 16'd4;
            end
`else
            if (sck_fall) miso_q <= 1'b0;
`endif
          end
          default: spi_state <= S_IDLE;
        endcase
      end
    end
  end

  // WISHBONE master: one classic cycle per request, aborted with an error after TIMEOUT clocks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_state <= WB_IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_timer <= '0;
      rd_dat   <= '0;
      err_o    <= 1'b0;
    end else begin
      if (err_clr) err_o <= 1'b0;
      if (wb_state == WB_IDLE) begin
        if (req_vld) begin
          wb_state <= WB_BUSY;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= req_we;
          wb_adr_o <= req_adr;
          wb_dat_o <= req_dat;
          wb_timer <= '0;
        end
      end else begin
        // A request arriving while a cycle is outstanding is dropped and flagged.
        if (req_vld) err_o <= 1'b1;
        if (wb_ack_i) begin
          wb_state <= WB_IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          if (!wb_we_o) rd_dat <= wb_dat_i;
        end else if (wb_timer == TO_LAST) begin
          wb_state <= WB_IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          err_o    <= 1'b1;
          if (!wb_we_o) rd_dat <= 32'hDEADDEAD;
        end else begin
          wb_timer <= wb_timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_surf4_spi_wb_bridge.sv
// Bench for surf4_spi_wb_bridge: an SPI master task drives frames, a WISHBONE slave process logs cycles,
// and each test compares against expectations derived from the frame contents and slave behaviour.
// Burst expectations follow SURF4_SPI_WB_BURST_EN when it is defined for the build.
module tb_surf4_spi_wb_bridge;

  localparam int HALF = 80;   // SCK half period: 8 clk periods
  localparam int GAP  = 60;   // idle clocks after CS_B rises

  logic        clk, rst;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        SCK, CS_B, MOSI, MISO, MISO_OE, err_o;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          ack_lat;
  logic [31:0] slave_rdata;
  logic [15:0] q_adr[$];
  logic [31:0] q_dat[$];
  logic        q_we[$];
  logic [3:0]  q_sel[$];
  int          last_len, cyc_len, stb_viol, ack_viol;
  bit          seen;

  logic [95:0] miso_bits;
  logic        oe_all;
  logic        cyc_pre_rst, cyc_in_rst, stb_in_rst, oe_in_rst;

  surf4_spi_wb_bridge #(.TIMEOUT(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .SCK(SCK), .CS_B(CS_B), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // WISHBONE slave: logs each cycle, acks after ack_lat sampled cycles (0 = never), tracks protocol slips.
  initial begin
    wb_ack_i = 1'b0; wb_dat_i = '0; seen = 0; cyc_len = 0; last_len = -1; stb_viol = 0; ack_viol = 0;
    forever begin
      @(negedge clk);
      if (wb_stb_o !== wb_cyc_o) stb_viol++;
      if (rst) begin
        wb_ack_i = 1'b0; seen = 0;
      end else if (wb_ack_i) begin
        wb_ack_i = 1'b0; wb_dat_i = '0; seen = 0;
        if (wb_cyc_o) ack_viol++;
      end else if (wb_cyc_o) begin
        if (!seen) begin
          seen = 1; cyc_len = 0;
          q_adr.push_back(wb_adr_o); q_dat.push_back(wb_dat_o);
          q_we.push_back(wb_we_o);   q_sel.push_back(wb_sel_o);
        end
        cyc_len++;
        if (ack_lat > 0 && cyc_len >= ack_lat) begin
          wb_ack_i = 1'b1; wb_dat_i = slave_rdata;
        end
      end else if (seen) begin
        seen = 0; last_len = cyc_len;
      end
    end
  end

  function automatic logic [95:0] mk_frame(logic [7:0] cmd, logic [15:0] adr, logic [31:0] d0, logic [31:0] d1);
    return {cmd, adr, 8'h00, d0, d1};
  endfunction

  // SPI mode-0 master; din is MSB-aligned. rst_bit >= 0 pulses rst just before that bit is clocked.
  task automatic spi_xfer(input logic [95:0] din, input int nbits, input int rst_bit, input int gap);
    miso_bits = '0; oe_all = 1'b1;
    @(negedge clk);
    CS_B = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = din[95-i];
      if (i == rst_bit) begin
        cyc_pre_rst = wb_cyc_o;
        rst = 1'b1;
        #1;
        cyc_in_rst = wb_cyc_o; stb_in_rst = wb_stb_o; oe_in_rst = MISO_OE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      #HALF;
      miso_bits[95-i] = MISO;
      oe_all = oe_all & MISO_OE;
      SCK = 1'b1;
      #HALF;
      SCK = 1'b0;
    end
    #HALF;
    CS_B = 1'b1; MOSI = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; CS_B = 1'b1; SCK = 1'b0; MOSI = 1'b0; ack_lat = 0; slave_rdata = '0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_cyc: got %b expected 0", wb_cyc_o); end
    n_checks++; if (wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b expected 0", wb_stb_o); end
    n_checks++; if (wb_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", wb_we_o); end
    n_checks++; if (wb_adr_o !== 16'h0) begin n_fail++; $display("FAIL rst_adr: got %h expected 0000", wb_adr_o); end
    n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h expected 0", wb_dat_o); end
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b expected 0", MISO); end
    n_checks++; if (MISO_OE !== 1'b0) begin n_fail++; $display("FAIL rst_miso_oe: got %b expected 0", MISO_OE); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_o); end
    n_checks++; if (wb_sel_o !== 4'hF) begin n_fail++; $display("FAIL rst_sel: got %h expected f", wb_sel_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_write;
    int base = q_adr.size();
    ack_lat = 2;
    spi_xfer(mk_frame(8'h80, 16'h000C, 32'h12345678, 32'h0), 64, -1, GAP);
    n_checks++; if (q_adr.size() !== base + 1) begin n_fail++; $display("FAIL wr_count: got %0d expected %0d", q_adr.size() - base, 1); end
    if (q_adr.size() > base) begin
      n_checks++; if (q_adr[base] !== 16'h000C) begin n_fail++; $display("FAIL wr_adr: got %h expected 000c", q_adr[base]); end
      n_checks++; if (q_dat[base] !== 32'h12345678) begin n_fail++; $display("FAIL wr_dat: got %h expected 12345678", q_dat[base]); end
      n_checks++; if (q_we[base] !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b expected 1", q_we[base]); end
      n_checks++; if (q_sel[base] !== 4'hF) begin n_fail++; $display("FAIL wr_sel: got %h expected f", q_sel[base]); end
    end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", err_o); end
    n_checks++; if (miso_bits[95:88] !== 8'h00) begin n_fail++; $display("FAIL wr_status: got %h expected 00", miso_bits[95:88]); end
    n_checks++; if (oe_all !== 1'b1) begin n_fail++; $display("FAIL wr_oe_in_frame: got %b expected 1", oe_all); end
    n_checks++; if (MISO_OE !== 1'b0) begin n_fail++; $display("FAIL wr_oe_after: got %b expected 0", MISO_OE); end
  endtask

  task automatic test_read;
    int base = q_adr.size();
    int exp_n = 1;
`ifdef SURF4_SPI_WB_BURST_EN
    exp_n = 2;
`endif
    ack_lat = 3; slave_rdata = 32'h53344137;
    spi_xfer(mk_frame(8'h00, 16'h0000, 32'h0, 32'h0), 64, -1, GAP);
    n_checks++; if (q_adr.size() !== base + exp_n) begin n_fail++; $display("FAIL rd_count: got %0d expected %0d", q_adr.size() - base, exp_n); end
    if (q_adr.size() > base) begin
      n_checks++; if (q_adr[base] !== 16'h0000) begin n_fail++; $display("FAIL rd_adr: got %h expected 0000", q_adr[base]); end
      n_checks++; if (q_we[base] !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b expected 0", q_we[base]); end
    end
    n_checks++; if (miso_bits[63:32] !== 32'h53344137) begin n_fail++; $display("FAIL rd_miso_data: got %h expected 53344137", miso_bits[63:32]); end
    n_checks++; if (miso_bits[95:88] !== 8'h00) begin n_fail++; $display("FAIL rd_status: got %h expected 00", miso_bits[95:88]); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b expected 0", err_o); end
  endtask

  task automatic test_timeout;
    int base = q_adr.size();
    ack_lat = 0; last_len = -1;
    spi_xfer(mk_frame(8'h00, 16'h0004, 32'h0, 32'h0), 64, -1, GAP);
    n_checks++; if (last_len !== 32) begin n_fail++; $display("FAIL to_cyc_len: got %0d expected 32", last_len); end
    if (q_adr.size() > base) begin
      n_checks++; if (q_adr[base] !== 16'h0004) begin n_fail++; $display("FAIL to_adr: got %h expected 0004", q_adr[base]); end
    end
    n_checks++; if (miso_bits[63:32] !== 32'hDEADDEAD) begin n_fail++; $display("FAIL to_miso_data: got %h expected deaddead", miso_bits[63:32]); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b expected 1", err_o); end
    ack_lat = 1; slave_rdata = 32'h0BADF00D;
    spi_xfer(mk_frame(8'h00, 16'h0000, 32'h0, 32'h0), 64, -1, GAP);
    n_checks++; if (miso_bits[95:88] !== 8'h80) begin n_fail++; $display("FAIL to_status: got %h expected 80", miso_bits[95:88]); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b expected 0", err_o); end
    n_checks++; if (miso_bits[63:32] !== 32'h0BADF00D) begin n_fail++; $display("FAIL to_next_data: got %h expected 0badf00d", miso_bits[63:32]); end
  endtask

  task automatic test_busy_status;
    ack_lat = 0;
    spi_xfer(mk_frame(8'h80, 16'h0040, 32'hCAFE0001, 32'h0), 64, -1, 2);
    spi_xfer(mk_frame(8'h00, 16'h0, 32'h0, 32'h0), 8, -1, GAP);
    n_checks++; if (miso_bits[95:88] !== 8'h40) begin n_fail++; $display("FAIL busy_status: got %h expected 40", miso_bits[95:88]); end
    spi_xfer(mk_frame(8'h00, 16'h0, 32'h0, 32'h0), 8, -1, GAP);
  endtask

  task automatic test_abort;
    int base = q_adr.size();
    ack_lat = 1;
    spi_xfer(mk_frame(8'h80, 16'h0030, 32'h11112222, 32'h0), 12, -1, GAP);
    n_checks++; if (q_adr.size() !== base) begin n_fail++; $display("FAIL abort_no_cycle: got %0d expected 0", q_adr.size() - base); end
    spi_xfer(mk_frame(8'h80, 16'h0100, 32'hA5A50F0F, 32'h0), 64, -1, GAP);
    n_checks++; if (q_adr.size() !== base + 1) begin n_fail++; $display("FAIL abort_next_count: got %0d expected 1", q_adr.size() - base); end
    if (q_adr.size() > base) begin
      n_checks++; if (q_adr[base] !== 16'h0100) begin n_fail++; $display("FAIL abort_next_adr: got %h expected 0100", q_adr[base]); end
      n_checks++; if (q_dat[base] !== 32'hA5A50F0F) begin n_fail++; $display("FAIL abort_next_dat: got %h expected a5a50f0f", q_dat[base]); end
    end
  endtask

  task automatic test_burst;
    int base = q_adr.size();
    ack_lat = 1;
    spi_xfer(mk_frame(8'h80, 16'hFFFC, 32'h1, 32'h2), 96, -1, GAP);
    if (q_adr.size() > base) begin
      n_checks++; if (q_adr[base] !== 16'hFFFC) begin n_fail++; $display("FAIL burst_adr0: got %h expected fffc", q_adr[base]); end
      n_checks++; if (q_dat[base] !== 32'h1) begin n_fail++; $display("FAIL burst_dat0: got %h expected 1", q_dat[base]); end
    end
`ifdef SURF4_SPI_WB_BURST_EN
    n_checks++; if (q_adr.size() !== base + 2) begin n_fail++; $display("FAIL burst_count: got %0d expected 2", q_adr.size() - base); end
    if (q_adr.size() > base + 1) begin
      n_checks++; if (q_adr[base+1] !== 16'h0000) begin n_fail++; $display("FAIL burst_adr1: got %h expected 0000", q_adr[base+1]); end
      n_checks++; if (q_dat[base+1] !== 32'h2) begin n_fail++; $display("FAIL burst_dat1: got %h expected 2", q_dat[base+1]); end
    end
`else
    n_checks++; if (q_adr.size() !== base + 1) begin n_fail++; $display("FAIL burst_count: got %0d expected 1", q_adr.size() - base); end
`endif
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL burst_err: got %b expected 0", err_o); end
  endtask

  task automatic test_reset_busy;
    int base = q_adr.size();
    logic [31:0] wd = $urandom;
    ack_lat = 0;
    spi_xfer(mk_frame(8'h00, 16'h0008, 32'h0, 32'h0), 64, 24, GAP);
    n_checks++; if (cyc_pre_rst !== 1'b1) begin n_fail++; $display("FAIL rstb_busy_before: got %b expected 1", cyc_pre_rst); end
    n_checks++; if (cyc_in_rst !== 1'b0) begin n_fail++; $display("FAIL rstb_cyc: got %b expected 0", cyc_in_rst); end
    n_checks++; if (stb_in_rst !== 1'b0) begin n_fail++; $display("FAIL rstb_stb: got %b expected 0", stb_in_rst); end
    n_checks++; if (oe_in_rst !== 1'b0) begin n_fail++; $display("FAIL rstb_oe: got %b expected 0", oe_in_rst); end
    n_checks++; if (q_adr.size() !== base + 1) begin n_fail++; $display("FAIL rstb_count: got %0d expected 1", q_adr.size() - base); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rstb_err: got %b expected 0", err_o); end
    base = q_adr.size();
    ack_lat = 2;
    spi_xfer(mk_frame(8'h80, 16'h0010, wd, 32'h0), 64, -1, GAP);
    n_checks++; if (q_adr.size() !== base + 1) begin n_fail++; $display("FAIL rstb_next_count: got %0d expected 1", q_adr.size() - base); end
    if (q_adr.size() > base) begin
      n_checks++; if (q_dat[base] !== wd) begin n_fail++; $display("FAIL rstb_next_dat: got %h expected %h", q_dat[base], wd); end
    end
    n_checks++; if (miso_bits[95:88] !== 8'h00) begin n_fail++; $display("FAIL rstb_next_status: got %h expected 00", miso_bits[95:88]); end
  endtask

  task automatic test_random;
    logic m_err = 1'b0;
    for (int it = 0; it < 12; it++) begin
      logic        we    = 1'($urandom_range(0, 1));
      logic [15:0] adr   = 16'($urandom);
      logic [31:0] dat   = $urandom;
      logic [7:0]  cmd   = {we, 7'($urandom)};
      int          lat   = $urandom_range(0, 5);
      int          base  = q_adr.size();
      int          exp_n = 1;
      logic [7:0]  e_st  = {m_err, 7'b0};
      logic [31:0] e_rd;
      ack_lat = lat; slave_rdata = $urandom;
      e_rd = (lat > 0) ? slave_rdata : 32'hDEADDEAD;
`ifdef SURF4_SPI_WB_BURST_EN
      if (!we) exp_n = 2;
`endif
      m_err = (lat == 0);
      spi_xfer(mk_frame(cmd, adr, dat, 32'h0), 64, -1, GAP);
      n_checks++; if (miso_bits[95:88] !== e_st) begin n_fail++; $display("FAIL rnd%0d_status: got %h expected %h", it, miso_bits[95:88], e_st); end
      n_checks++; if (q_adr.size() !== base + exp_n) begin n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, q_adr.size() - base, exp_n); end
      if (q_adr.size() > base) begin
        n_checks++; if (q_adr[base] !== adr) begin n_fail++; $display("FAIL rnd%0d_adr: got %h expected %h", it, q_adr[base], adr); end
        n_checks++; if (q_we[base] !== we) begin n_fail++; $display("FAIL rnd%0d_we: got %b expected %b", it, q_we[base], we); end
        if (we) begin
          n_checks++; if (q_dat[base] !== dat) begin n_fail++; $display("FAIL rnd%0d_dat: got %h expected %h", it, q_dat[base], dat); end
        end
      end
      if (!we) begin
        n_checks++; if (miso_bits[63:32] !== e_rd) begin n_fail++; $display("FAIL rnd%0d_miso_data: got %h expected %h", it, miso_bits[63:32], e_rd); end
      end
      n_checks++; if (err_o !== m_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", it, err_o, m_err); end
    end
  endtask

  task automatic test_protocol;
    n_checks++; if (stb_viol !== 0) begin n_fail++; $display("FAIL proto_stb_eq_cyc: got %0d slips expected 0", stb_viol); end
    n_checks++; if (ack_viol !== 0) begin n_fail++; $display("FAIL proto_drop_after_ack: got %0d slips expected 0", ack_viol); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_busy_status();
    test_abort();
    test_burst();
    test_reset_busy();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
